// File: rtl/rr_slave_arbiter.sv
// Round-robin arbiter for one crossbar slave port: grants one requesting master at a time,
// holds the grant until done, master withdrawal or watchdog expiry, then idles one release cycle.
module rr_slave_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned IDX_W     = 1,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 done,
    output logic [N_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTERS - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic             WD_EN    = (TIMEOUT != 0);

    state_t               state, state_n;
    logic [CNT_W-1:0]     wd_cnt, wd_cnt_n;
    logic [IDX_W-1:0]     last_ptr, last_ptr_n;
    logic [N_MASTERS-1:0] grant_n;
    logic [IDX_W-1:0]     grant_id_n;
    logic                 busy_n;
    logic                 timeout_err_n;

    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;
    int unsigned          cand;

    // First requester strictly after last_ptr, wrapping around.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            cand = 32'(last_ptr) + k;
            if (cand >= N_MASTERS) begin
                cand = cand - N_MASTERS;
            end
            if (!sel_valid && req[IDX_W'(cand)]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wd_cnt      <= '0;
            last_ptr    <= LAST_RST;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            wd_cnt      <= wd_cnt_n;
            last_ptr    <= last_ptr_n;
            grant       <= grant_n;
            grant_id    <= grant_id_n;
            busy        <= busy_n;
            timeout_err <= timeout_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        wd_cnt_n      = wd_cnt;
        last_ptr_n    = last_ptr;
        grant_n       = grant;
        grant_id_n    = grant_id;
        busy_n        = busy;
        timeout_err_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_n    = ST_BUSY;
                    grant_n    = N_MASTERS'(1) << sel_idx;
                    grant_id_n = sel_idx;
                    busy_n     = 1'b1;
                    wd_cnt_n   = '0;
                end
            end
            ST_BUSY: begin
                // done outranks withdrawal, which outranks the watchdog.
                if (done || !req[grant_id] || (WD_EN && (wd_cnt == WD_LAST))) begin
                    state_n       = ST_RELEASE;
                    last_ptr_n    = grant_id;
                    grant_n       = '0;
                    busy_n        = 1'b0;
                    wd_cnt_n      = '0;
                    timeout_err_n = !done && req[grant_id];
                end else begin
                    wd_cnt_n = wd_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_slave_arbiter.sv
// Bench for rr_slave_arbiter: directed tables on a 2-master/TIMEOUT=4 instance and
// randomized traffic on a 4-master/TIMEOUT=5 instance against a transaction-level model.
module tb_rr_slave_arbiter;

    localparam int NA = 4;
    localparam int IA = 2;
    localparam int TA = 5;
    localparam int CA = 3;
    localparam int NB = 2;
    localparam int IB = 1;
    localparam int TB = 4;
    localparam int CB = 3;

    logic          clk = 1'b0;
    logic          rst_a, rst_b;
    logic [NA-1:0] req_a;
    logic          done_a;
    logic [NA-1:0] grant_a;
    logic [IA-1:0] id_a;
    logic          busy_a, err_a;
    logic [NB-1:0] req_b;
    logic          done_b;
    logic [NB-1:0] grant_b;
    logic [IB-1:0] id_b;
    logic          busy_b, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_slave_arbiter #(.N_MASTERS(NA), .IDX_W(IA), .TIMEOUT(TA), .CNT_W(CA)) u_a (
        .clock(clk), .reset_n(rst_a), .req(req_a), .done(done_a),
        .grant(grant_a), .grant_id(id_a), .busy(busy_a), .timeout_err(err_a)
    );

    rr_slave_arbiter #(.N_MASTERS(NB), .IDX_W(IB), .TIMEOUT(TB), .CNT_W(CB)) u_b (
        .clock(clk), .reset_n(rst_b), .req(req_b), .done(done_b),
        .grant(grant_b), .grant_id(id_b), .busy(busy_b), .timeout_err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of u_a: who owns the slave, how long it has held it, pending gap cycles.
    int   m_owner, m_held, m_gap, m_last;
    logic m_err;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_last  = NA - 1;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        logic fin, tmo;
        m_err = 1'b0;
        if (m_owner >= 0) begin
            tmo = (TA != 0) && (m_held + 1 == TA);
            fin = done_a || !req_a[m_owner] || tmo;
            if (fin) begin
                m_err   = !done_a && req_a[m_owner];
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req_a != '0) begin
            for (int k = 1; k <= NA; k++) begin
                if (m_owner < 0 && req_a[(m_last + k) % NA]) begin
                    m_owner = (m_last + k) % NA;
                end
            end
            m_held = 0;
        end
    endtask

    task automatic check_a();
        check("a_grant", 32'(grant_a), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("a_busy", 32'(busy_a), 32'(m_owner >= 0));
        check("a_err", 32'(err_a), 32'(m_err));
        if (m_owner >= 0) check("a_id", 32'(id_a), 32'(m_owner));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_a();
    endtask

    typedef struct {
        logic [NB-1:0] req;
        logic          done;
        logic [NB-1:0] grant;
        logic [IB-1:0] id;
        logic          busy;
        logic          err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] r, input logic d, input logic [1:0] g,
                       input logic i, input logic e);
        vec_t v;
        v.req = r; v.done = d; v.grant = g; v.id = i; v.busy = (g != 2'b00); v.err = e;
        tbl.push_back(v);
    endtask

    initial begin
        int gap;
        int waited;
        rst_a = 1'b0; rst_b = 1'b0;
        req_a = '0; done_a = 1'b0; req_b = '0; done_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant_b", 32'(grant_b), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_id_b", 32'(id_b), 32'd0);
        check("rst_err_b", 32'(err_b), 32'd0);
        check_a();
        rst_a = 1'b1; rst_b = 1'b1;

        // Four masters all requesting, done three cycles after each grant.
        req_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            waited = 0;
            while (!busy_a && waited < 10) begin
                tick();
                waited++;
            end
            check($sformatf("order%0d", k), 32'(id_a), 32'(k % NA));
            tick();
            tick();
            done_a = 1'b1;
            tick();
            done_a = 1'b0;
            if (k < 4) begin
                gap = 0;
                while (!busy_a && gap < 10) begin
                    gap++;
                    tick();
                end
                check($sformatf("gap%0d", k), 32'(gap), 32'd2);
            end
        end
        req_a = '0;
        repeat (3) tick();

        // Two-master directed sequence: basic, abort, done+drop, pointer, timeout, stray done.
        add(2'b11, 0, 2'b01, 0, 0);
        add(2'b11, 1, 2'b00, 0, 0);
        add(2'b11, 0, 2'b00, 0, 0);
        add(2'b11, 0, 2'b10, 1, 0);
        add(2'b01, 0, 2'b00, 0, 0);
        add(2'b01, 0, 2'b00, 0, 0);
        add(2'b01, 0, 2'b01, 0, 0);
        add(2'b00, 1, 2'b00, 0, 0);
        add(2'b00, 0, 2'b00, 0, 0);
        add(2'b00, 0, 2'b00, 0, 0);
        add(2'b11, 0, 2'b10, 1, 0);
        add(2'b11, 1, 2'b00, 0, 0);
        add(2'b01, 0, 2'b00, 0, 0);
        add(2'b01, 0, 2'b01, 0, 0);
        add(2'b01, 0, 2'b01, 0, 0);
        add(2'b01, 0, 2'b01, 0, 0);
        add(2'b01, 0, 2'b01, 0, 0);
        add(2'b01, 0, 2'b00, 0, 1);
        add(2'b01, 0, 2'b00, 0, 0);
        add(2'b01, 0, 2'b01, 0, 0);
        add(2'b01, 1, 2'b00, 0, 0);
        add(2'b00, 0, 2'b00, 0, 0);
        add(2'b00, 0, 2'b00, 0, 0);
        add(2'b00, 1, 2'b00, 0, 0);
        add(2'b01, 1, 2'b01, 0, 0);
        add(2'b01, 0, 2'b01, 0, 0);
        add(2'b01, 1, 2'b00, 0, 0);
        add(2'b00, 0, 2'b00, 0, 0);
        add(2'b00, 0, 2'b00, 0, 0);
        foreach (tbl[i]) begin
            req_b  = tbl[i].req;
            done_b = tbl[i].done;
            tick();
            check($sformatf("tbl%0d_grant", i), 32'(grant_b), 32'(tbl[i].grant));
            check($sformatf("tbl%0d_busy", i), 32'(busy_b), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_err", i), 32'(err_b), 32'(tbl[i].err));
            if (tbl[i].busy) check($sformatf("tbl%0d_id", i), 32'(id_b), 32'(tbl[i].id));
        end
        done_b = 1'b0;

        // Async reset while master 1 owns the slave.
        req_b = 2'b10;
        tick();
        check("r6_pre_grant", 32'(grant_b), 32'b10);
        #2 rst_b = 1'b0;
        #1;
        check("r6_async_grant", 32'(grant_b), 32'd0);
        check("r6_async_busy", 32'(busy_b), 32'd0);
        #1 rst_b = 1'b1;
        req_b = 2'b11;
        tick();
        check("r6_post_grant", 32'(grant_b), 32'b01);
        check("r6_post_id", 32'(id_b), 32'd0);
        req_b = '0;

        // Randomized traffic with one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            req_a  = req_a ^ NA'($urandom_range(0, 7) == 0 ? $urandom_range(1, 15) : 0);
            done_a = ($urandom_range(0, 5) == 0);
            if (c == 1500) begin
                rst_a = 1'b0;
                #1;
                model_reset();
                check_a();
                #1 rst_a = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
